// File: rtl/instruction_decode.sv
// ID stage: register file with write-through bypass, load-use stall, bubble/halt control, branch/jump targets.
// Optional define REGFILE_DEBUG_PORT_EN adds a combinational, non-bypassed register read port.
module instruction_decode #(
  parameter int len = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [len-1:0] in_pc_branch,
  input  logic [len-1:0] in_instruction,
  input  logic           in_enable,
  input  logic           in_flush,
  input  logic           in_wb_we,
  input  logic [4:0]     in_wb_rd,
  input  logic [len-1:0] in_wb_data,
  input  logic           in_ex_mem_read,
  input  logic [4:0]     in_ex_rt,
  output logic           out_pc_enable,
  output logic [len-1:0] out_rs_data,
  output logic [len-1:0] out_rt_data,
  output logic [len-1:0] out_imm_ext,
  output logic [4:0]     out_rs,
  output logic [4:0]     out_rt,
  output logic [4:0]     out_rd,
  output logic [5:0]     out_opcode,
  output logic [5:0]     out_funct,
  output logic [len-1:0] out_pc_branch,
  output logic [len-1:0] out_pc_jump,
  output logic           out_halt
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [4:0]     in_addr_debug,
  output logic [len-1:0] out_reg_debug
`endif
);

  typedef struct packed {
    logic [len-1:0] rs_data;
    logic [len-1:0] rt_data;
    logic [len-1:0] imm_ext;
    logic [4:0]     rs;
    logic [4:0]     rt;
    logic [4:0]     rd;
    logic [5:0]     opcode;
    logic [5:0]     funct;
    logic [len-1:0] pc_branch;
    logic [len-1:0] pc_jump;
  } id_out_t;

  logic [len-1:0] regs [32];
  logic [4:0]     rs_a, rt_a;
  logic [len-1:0] rs_val, rt_val, imm_ext;
  logic           hazard, halt_op;
  id_out_t        id_cap, id_q;

  assign rs_a    = in_instruction[25:21];
  assign rt_a    = in_instruction[20:16];
  assign imm_ext = {{(len-16){in_instruction[15]}}, in_instruction[15:0]};
  assign halt_op = (in_instruction[31:26] == 6'h3f);
  assign hazard  = in_ex_mem_read && (in_ex_rt != 5'd0) &&
                   ((in_ex_rt == rs_a) || (in_ex_rt == rt_a));

  assign out_pc_enable = in_enable & ~hazard & ~out_halt;

  // Same-cycle writeback is forwarded so the value is not lost to the write/read race.
  always_comb begin
    rs_val = regs[rs_a];
    rt_val = regs[rt_a];
    if (in_wb_we && (in_wb_rd != 5'd0) && (in_wb_rd == rs_a)) rs_val = in_wb_data;
    if (in_wb_we && (in_wb_rd != 5'd0) && (in_wb_rd == rt_a)) rt_val = in_wb_data;
    if (rs_a == 5'd0) rs_val = '0;
    if (rt_a == 5'd0) rt_val = '0;
  end

  always_comb begin
    id_cap           = '0;
    id_cap.rs_data   = rs_val;
    id_cap.rt_data   = rt_val;
    id_cap.imm_ext   = imm_ext;
    id_cap.rs        = rs_a;
    id_cap.rt        = rt_a;
    id_cap.rd        = in_instruction[15:11];
    id_cap.opcode    = in_instruction[31:26];
    id_cap.funct     = in_instruction[5:0];
    id_cap.pc_branch = in_pc_branch + imm_ext;
    id_cap.pc_jump   = {in_pc_branch[len-1:26], in_instruction[25:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (in_wb_we && (in_wb_rd != 5'd0)) begin
      regs[in_wb_rd] <= in_wb_data;
    end
  end

  // Flush outranks the halt opcode, so a squashed halt never sets out_halt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q     <= '0;
      out_halt <= 1'b0;
    end else if (in_flush || hazard || out_halt) begin
      id_q <= '0;
    end else if (in_enable) begin
      if (halt_op) begin
        id_q     <= '0;
        out_halt <= 1'b1;
      end else begin
        id_q <= id_cap;
      end
    end
  end

  assign out_rs_data   = id_q.rs_data;
  assign out_rt_data   = id_q.rt_data;
  assign out_imm_ext   = id_q.imm_ext;
  assign out_rs        = id_q.rs;
  assign out_rt        = id_q.rt;
  assign out_rd        = id_q.rd;
  assign out_opcode    = id_q.opcode;
  assign out_funct     = id_q.funct;
  assign out_pc_branch = id_q.pc_branch;
  assign out_pc_jump   = id_q.pc_jump;

`ifdef REGFILE_DEBUG_PORT_EN
  assign out_reg_debug = regs[in_addr_debug];
`endif

endmodule
